packet_dispatch_1_to_n: RTL and testbench

Parametrised 1-to-N AXI-stream packet dispatcher. It is the successor to the fixed ctl-routed 1-to-N packet arbiter. It adds three things: a round-robin load-balancing mode, dropping of packets with an out-of-range destination, and a registered per-output stage with packet-atomic routing. It sits between a single producer (e.g. the host DMA or ingress parser) and NUM_OUT parallel compute cores.

---
 rtl/packet_dispatch_pkg.sv | 22 ++
 rtl/packet_dispatch_1_to_n_if.sv | 22 ++
 rtl/packet_dispatch_1_to_n_out_reg.sv | 63 ++++++
 rtl/packet_dispatch_1_to_n.sv | 158 +++++++++++++++
 tb/tb_packet_dispatch_1_to_n.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_dispatch_pkg.sv
// Shared types and sizing helpers for the 1-to-N packet dispatcher.
package packet_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } dispatch_state_t;

  localparam int unsigned MODE_CTL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Index width for n outputs; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned mod_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packet_dispatch_1_to_n_if.sv
// AXI-stream style packet interface with sop/eop framing and ctl sideband.
interface if_axi_stream #(
  parameter int unsigned DAT_BYTS = 8,
  parameter int unsigned CTL_BITS = 8
) ();
  import packet_dispatch_pkg::*;

  localparam int unsigned MOD_BITS = mod_bits(DAT_BYTS);

  logic                    val;
  logic                    rdy;
  logic                    sop;
  logic                    eop;
  logic                    err;
  logic [DAT_BYTS*8-1:0]   dat;
  logic [CTL_BITS-1:0]     ctl;
  logic [MOD_BITS-1:0]     mod;

  modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);

endinterface

// File: rtl/packet_dispatch_1_to_n_out_reg.sv
// One-entry output register slot: loads on i_load, holds until the sink takes it.
module packet_out_reg
  import packet_dispatch_pkg::*;
#(
  parameter  int unsigned DAT_BYTS = 8,
  parameter  int unsigned CTL_BITS = 8,
  localparam int unsigned MOD_BITS = mod_bits(DAT_BYTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic                  i_err,
  input  logic [DAT_BYTS*8-1:0] i_dat,
  input  logic [CTL_BITS-1:0]   i_ctl,
  input  logic [MOD_BITS-1:0]   i_mod,
  output logic                  o_free_c,
  if_axi_stream.master          o_axi
);

  logic                  r_val;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_err;
  logic [DAT_BYTS*8-1:0] r_dat;
  logic [CTL_BITS-1:0]   r_ctl;
  logic [MOD_BITS-1:0]   r_mod;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_val <= 1'b0;
      r_sop <= 1'b0;
      r_eop <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      r_ctl <= '0;
      r_mod <= '0;
    end else if (i_load) begin
      r_val <= 1'b1;
      r_sop <= i_sop;
      r_eop <= i_eop;
      r_err <= i_err;
      r_dat <= i_dat;
      r_ctl <= i_ctl;
      r_mod <= i_mod;
    end else if (o_axi.rdy) begin
      r_val <= 1'b0;
    end
  end

  // Slot can take a new beat this cycle if empty or draining.
  assign o_free_c  = !r_val || o_axi.rdy;

  assign o_axi.val = r_val;
  assign o_axi.sop = r_sop;
  assign o_axi.eop = r_eop;
  assign o_axi.err = r_err;
  assign o_axi.dat = r_dat;
  assign o_axi.ctl = r_ctl;
  assign o_axi.mod = r_mod;

endmodule

// File: rtl/packet_dispatch_1_to_n.sv
// 1-to-N packet dispatcher: ctl-indexed or round-robin routing, drop of bad
// destinations, packet-atomic destination lock and per-output register slots.
module packet_dispatch_1_to_n
  import packet_dispatch_pkg::*;
#(
  parameter int unsigned DAT_BYTS    = 8,
  parameter int unsigned CTL_BITS    = 8,
  parameter int unsigned NUM_OUT     = 8,
  parameter int unsigned MODE        = MODE_CTL,
  parameter int unsigned OVR_WRT_BIT = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  if_axi_stream.slave  i_axi,
  if_axi_stream.master o_n_axi [NUM_OUT],
  output logic         o_err,
  output logic         o_busy
);

  localparam int unsigned IDX_BITS = idx_bits(NUM_OUT);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ROUTE = 2'(ROUTE);
  localparam logic [1:0] S_DROP  = 2'(DROP);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [IDX_BITS-1:0] r_dest;
  logic [IDX_BITS-1:0] w_dest_nxt;
  logic [IDX_BITS-1:0] r_rr_ptr;
  logic [IDX_BITS-1:0] w_rr_nxt;
  logic [IDX_BITS-1:0] w_rr_inc;
  logic [IDX_BITS-1:0] w_dec_dest;
  logic [IDX_BITS-1:0] w_sel_dest;
  logic                w_dec_ok;
  logic                w_rdy;
  logic                w_beat;
  logic                w_fwd;
  logic                w_err_nxt;
  logic                r_err;
  logic                r_busy;
  logic [NUM_OUT-1:0]  w_free;
  logic [NUM_OUT-1:0]  w_load;
  logic [CTL_BITS-1:0] w_ctl;

  // Destination decode and ctl rewrite depend on the routing mode.
  generate
    if (MODE == MODE_RR) begin : g_rr
      assign w_dec_dest = r_rr_ptr;
      assign w_dec_ok   = 1'b1;
      always_comb begin
        w_ctl = i_axi.ctl;
        w_ctl[OVR_WRT_BIT +: IDX_BITS] = w_sel_dest;
      end
    end else begin : g_ctl
      assign w_dec_dest = i_axi.ctl[OVR_WRT_BIT +: IDX_BITS];
      assign w_dec_ok   = (32'(w_dec_dest) < NUM_OUT);
      assign w_ctl      = i_axi.ctl;
    end
  endgenerate

  assign w_sel_dest = (r_state == S_IDLE) ? w_dec_dest : r_dest;
  assign w_rr_inc   = (32'(r_rr_ptr) == NUM_OUT - 1) ? '0 : r_rr_ptr + IDX_BITS'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_dest_nxt  = r_dest;
    w_rr_nxt    = r_rr_ptr;
    w_err_nxt   = 1'b0;
    w_fwd       = 1'b0;
    w_rdy       = 1'b0;
    w_beat      = 1'b0;

    unique case (r_state)
      S_IDLE:  w_rdy = !i_axi.sop || !w_dec_ok || w_free[w_sel_dest];
      S_ROUTE: w_rdy = w_free[r_dest];
      S_DROP:  w_rdy = 1'b1;
      default: w_rdy = 1'b0;
    endcase
    w_rdy  = w_rdy && !i_rst;
    w_beat = i_axi.val && w_rdy;

    unique case (r_state)
      S_IDLE: begin
        if (w_beat) begin
          if (!i_axi.sop) begin
            w_err_nxt = 1'b1;
          end else if (!w_dec_ok) begin
            w_err_nxt = 1'b1;
            if (!i_axi.eop) w_state_nxt = S_DROP;
          end else begin
            w_fwd      = 1'b1;
            w_dest_nxt = w_dec_dest;
            if (i_axi.eop) w_rr_nxt = w_rr_inc;
            else           w_state_nxt = S_ROUTE;
          end
        end
      end
      S_ROUTE: begin
        if (w_beat) begin
          w_fwd = 1'b1;
          if (i_axi.eop) begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = w_rr_inc;
          end
        end
      end
      S_DROP: begin
        if (w_beat && i_axi.eop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_dest   <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dest   <= w_dest_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign i_axi.rdy = w_rdy;
  assign o_err     = r_err;
  assign o_busy    = r_busy;

  generate
    for (genvar g = 0; g < int'(NUM_OUT); g++) begin : g_out
      assign w_load[g] = w_fwd && (w_sel_dest == IDX_BITS'(g));

      packet_out_reg #(
        .DAT_BYTS (DAT_BYTS),
        .CTL_BITS (CTL_BITS)
      ) u_slot (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load[g]),
        .i_sop    (i_axi.sop),
        .i_eop    (i_axi.eop),
        .i_err    (i_axi.err),
        .i_dat    (i_axi.dat),
        .i_ctl    (w_ctl),
        .i_mod    (i_axi.mod),
        .o_free_c (w_free[g]),
        .o_axi    (o_n_axi[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_packet_dispatch_1_to_n.sv
// Scoreboard bench: DUT A is CTL mode with 6 outputs, DUT B is RR mode with 5 outputs.
module tb_packet_dispatch_1_to_n;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        err;
    logic [2:0]  mod;
    logic [7:0]  ctl;
    logic [63:0] dat;
  } beat_t;

  typedef struct {
    string       nm;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst;
  logic a_err, a_busy, b_err, b_busy;

  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) a_in  ();
  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) a_out [6] ();
  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) b_in  ();
  if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) b_out [5] ();

  logic [5:0] a_val, a_ordy;
  logic [4:0] b_val, b_ordy;
  beat_t      a_obeat [6];
  beat_t      b_obeat [5];

  beat_t exp_a [6][$];
  beat_t exp_b [5][$];
  chk_t  chk_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int a_err_seen = 0;
  int b_err_seen = 0;
  beat_t mon_e;
  chk_t  mon_c;
  logic [7:0] rr_ctl [5];

  always #5 clk = ~clk;

  packet_dispatch_1_to_n #(
    .DAT_BYTS(8), .CTL_BITS(8), .NUM_OUT(6), .MODE(0), .OVR_WRT_BIT(0)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_axi(a_in), .o_n_axi(a_out), .o_err(a_err), .o_busy(a_busy)
  );

  packet_dispatch_1_to_n #(
    .DAT_BYTS(8), .CTL_BITS(8), .NUM_OUT(5), .MODE(1), .OVR_WRT_BIT(1)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_axi(b_in), .o_n_axi(b_out), .o_err(b_err), .o_busy(b_busy)
  );

  generate
    for (genvar g = 0; g < 6; g++) begin : g_a
      assign a_out[g].rdy = a_ordy[g];
      assign a_val[g]     = a_out[g].val;
      assign a_obeat[g]   = {a_out[g].sop, a_out[g].eop, a_out[g].err, a_out[g].mod,
                             a_out[g].ctl, a_out[g].dat};
    end
    for (genvar g = 0; g < 5; g++) begin : g_b
      assign b_out[g].rdy = b_ordy[g];
      assign b_val[g]     = b_out[g].val;
      assign b_obeat[g]   = {b_out[g].sop, b_out[g].eop, b_out[g].err, b_out[g].mod,
                             b_out[g].ctl, b_out[g].dat};
    end
  endgenerate

  // Monitor: pops the scoreboard on every output handshake and drains queued checks.
  always @(negedge clk) begin
    for (int g = 0; g < 6; g++) begin
      if (a_val[g] && a_ordy[g]) begin
        n_cmp++;
        if (exp_a[g].size() == 0) begin
          n_bad++;
          $display("FAIL a_out%0d unexpected beat: got %h, required none", g, a_obeat[g]);
        end else begin
          mon_e = exp_a[g].pop_front();
          if (a_obeat[g] !== mon_e) begin
            n_bad++;
            $display("FAIL a_out%0d beat: got %h, required %h", g, a_obeat[g], mon_e);
          end
        end
      end
    end
    for (int g = 0; g < 5; g++) begin
      if (b_val[g] && b_ordy[g]) begin
        n_cmp++;
        if (exp_b[g].size() == 0) begin
          n_bad++;
          $display("FAIL b_out%0d unexpected beat: got %h, required none", g, b_obeat[g]);
        end else begin
          mon_e = exp_b[g].pop_front();
          if (b_obeat[g] !== mon_e) begin
            n_bad++;
            $display("FAIL b_out%0d beat: got %h, required %h", g, b_obeat[g], mon_e);
          end
        end
      end
    end
    if (a_err) a_err_seen++;
    if (b_err) b_err_seen++;
    while (chk_q.size() != 0) begin
      mon_c = chk_q.pop_front();
      n_cmp++;
      if (mon_c.act !== mon_c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h, required %0h", mon_c.nm, mon_c.act, mon_c.exp);
      end
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.nm  = nm;
    c.act = act;
    c.exp = exp;
    chk_q.push_back(c);
  endfunction

  function automatic logic [63:0] mk_dat(input logic [7:0] id, input int i);
    return {id, 8'(i), 40'h00DEC0DE00, 8'(i * 37)};
  endfunction

  // Drive one beat on DUT A (sel=0) or B (sel=1); dst<0 means it must not appear.
  task automatic send(input bit sel, input logic sop, input logic eop, input logic [7:0] ctl,
                      input logic [63:0] dat, input int dst, input logic [7:0] ectl,
                      inout int stalls);
    beat_t b;
    int    n;
    b.sop = sop; b.eop = eop; b.err = dat[48]; b.mod = dat[2:0]; b.ctl = ctl; b.dat = dat;
    if (sel) begin
      b_in.val = 1'b1; b_in.sop = sop; b_in.eop = eop; b_in.err = b.err;
      b_in.mod = b.mod; b_in.ctl = ctl; b_in.dat = dat;
    end else begin
      a_in.val = 1'b1; a_in.sop = sop; a_in.eop = eop; a_in.err = b.err;
      a_in.mod = b.mod; a_in.ctl = ctl; a_in.dat = dat;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if ((sel ? b_in.rdy : a_in.rdy) === 1'b1) break;
      n++;
      if (n >= 200) begin
        chk("accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    b.ctl = ectl;
    if (dst >= 0) begin
      if (sel) exp_b[dst].push_back(b);
      else     exp_a[dst].push_back(b);
    end
    stalls += n;
    if (sel) b_in.val = 1'b0;
    else     a_in.val = 1'b0;
  endtask

  task automatic pkt(input bit sel, input int dst, input int nb, input logic [7:0] ctl,
                     input logic [7:0] ectl, input logic [7:0] id, inout int stalls);
    for (int i = 0; i < nb; i++)
      send(sel, i == 0, i == nb - 1, ctl, mk_dat(id, i), dst, ectl, stalls);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int st;
    rr_ctl[0] = 8'hF1; rr_ctl[1] = 8'hF3; rr_ctl[2] = 8'hF5; rr_ctl[3] = 8'hF7; rr_ctl[4] = 8'hF9;
    rst = 1'b1;
    a_ordy = '1; b_ordy = '1;
    a_in.val = 1'b0; a_in.sop = 1'b0; a_in.eop = 1'b0; a_in.err = 1'b0;
    a_in.mod = '0;   a_in.ctl = '0;   a_in.dat = '0;
    b_in.val = 1'b0; b_in.sop = 1'b0; b_in.eop = 1'b0; b_in.err = 1'b0;
    b_in.mod = '0;   b_in.ctl = '0;   b_in.dat = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_in_rdy", 64'(a_in.rdy), 64'(0));
    chk("rst_b_in_rdy", 64'(b_in.rdy), 64'(0));
    chk("rst_a_val", 64'(a_val), 64'(0));
    chk("rst_b_val", 64'(b_val), 64'(0));
    chk("rst_a_err", 64'(a_err), 64'(0));
    chk("rst_a_busy", 64'(a_busy), 64'(0));
    chk("rst_b_busy", 64'(b_busy), 64'(0));
    chk("rst_a_payload", 64'(a_obeat[3]), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back 4-beat packets across all valid destinations.
    st = 0;
    for (int k = 0; k < 12; k++) pkt(0, k % 6, 4, 8'(k % 6), 8'(k % 6), 8'(k), st);
    chk("stream_stalls", 64'(st), 64'(0));

    // Destination boundaries: 5 last valid, 6/7 dropped, upper ctl bits ignored.
    st = 0;
    pkt(0, 5, 2, 8'h05, 8'h05, 8'h20, st);
    pkt(0, -1, 3, 8'h06, 8'h06, 8'h21, st);
    pkt(0, -1, 1, 8'h07, 8'h07, 8'h22, st);
    pkt(0, 2, 3, 8'h02, 8'h02, 8'h23, st);
    pkt(0, 2, 2, 8'hA2, 8'hA2, 8'h24, st);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_stalls", 64'(st), 64'(0));
    chk("err_after_drop", 64'(a_err_seen), 64'(2));

    // Single-beat packet, then a mid-packet sop that must not re-route.
    pkt(0, 4, 1, 8'h04, 8'h04, 8'h30, st);
    send(0, 1'b1, 1'b0, 8'h01, mk_dat(8'h31, 0), 1, 8'h01, st);
    send(0, 1'b1, 1'b0, 8'h03, mk_dat(8'h31, 1), 1, 8'h03, st);
    send(0, 1'b0, 1'b1, 8'h01, mk_dat(8'h31, 2), 1, 8'h01, st);

    // Orphan beats in IDLE are dropped with one error each.
    send(0, 1'b0, 1'b1, 8'h02, mk_dat(8'h40, 0), -1, 8'h02, st);
    send(0, 1'b0, 1'b0, 8'h03, mk_dat(8'h40, 1), -1, 8'h03, st);
    repeat (2) @(posedge clk);
    #1;
    chk("err_after_orphan", 64'(a_err_seen), 64'(4));
    chk("busy_after_orphan", 64'(a_busy), 64'(0));
    pkt(0, 0, 2, 8'h00, 8'h00, 8'h41, st);

    // Backpressure on output 3 holds the locked packet and the one queued behind it.
    a_ordy[3] = 1'b0;
    fork
      begin
        pkt(0, 3, 4, 8'h03, 8'h03, 8'h50, st);
        pkt(0, 1, 2, 8'h01, 8'h01, 8'h51, st);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_in_rdy", 64'(a_in.rdy), 64'(0));
        chk("bp_out3_val", 64'(a_val[3]), 64'(1));
        chk("bp_out1_val", 64'(a_val[1]), 64'(0));
        chk("bp_busy", 64'(a_busy), 64'(1));
        repeat (20) @(posedge clk);
        #1 a_ordy[3] = 1'b1;
      end
    join

    // Round robin on B: index field [3:1] overwritten, other bits kept.
    for (int k = 0; k < 12; k++) pkt(1, k % 5, 1, 8'hFF, rr_ctl[k % 5], 8'(8'h60 + k), st);
    pkt(1, 2, 3, 8'hFF, rr_ctl[2], 8'h70, st);
    pkt(1, 3, 1, 8'hFF, rr_ctl[3], 8'h71, st);

    // Reset mid-packet: beats parked in slot 4 of both DUTs are lost.
    a_ordy[4] = 1'b0;
    b_ordy[4] = 1'b0;
    send(1, 1'b1, 1'b0, 8'hFF, mk_dat(8'h80, 0), -1, 8'hF9, st);
    send(0, 1'b1, 1'b0, 8'h04, mk_dat(8'h81, 0), -1, 8'h04, st);
    a_in.val = 1'b1; a_in.sop = 1'b0; a_in.eop = 1'b0; a_in.dat = mk_dat(8'h81, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_a_busy", 64'(a_busy), 64'(1));
    chk("pre_rst_a_val4", 64'(a_val[4]), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_a_val", 64'(a_val), 64'(0));
    chk("mid_rst_b_val", 64'(b_val), 64'(0));
    chk("mid_rst_a_in_rdy", 64'(a_in.rdy), 64'(0));
    chk("mid_rst_a_busy", 64'(a_busy), 64'(0));
    @(posedge clk);
    #1;
    a_in.val = 1'b0;
    a_ordy = '1;
    b_ordy = '1;
    @(posedge clk);
    #1 rst = 1'b0;
    pkt(1, 0, 1, 8'hFF, rr_ctl[0], 8'h90, st);
    pkt(1, 1, 2, 8'hFF, rr_ctl[1], 8'h91, st);
    pkt(0, 4, 4, 8'h04, 8'h04, 8'h92, st);

    repeat (10) @(posedge clk);
    #1;
    chk("a_left", 64'(exp_a[0].size() + exp_a[1].size() + exp_a[2].size() +
                      exp_a[3].size() + exp_a[4].size() + exp_a[5].size()), 64'(0));
    chk("b_left", 64'(exp_b[0].size() + exp_b[1].size() + exp_b[2].size() +
                      exp_b[3].size() + exp_b[4].size()), 64'(0));
    chk("a_err_total", 64'(a_err_seen), 64'(4));
    chk("b_err_total", 64'(b_err_seen), 64'(0));
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
